// File: rtl/lifo_stack_buf.sv
// Parametrised LIFO stack with on-chip storage, registered top-of-stack output,
// occupancy thresholds and sticky overflow/underflow flags.
module lifo_stack_buf #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned AFULL_LVL  = DEPTH - 1,
  parameter int unsigned AEMPTY_LVL = 1,
  parameter int unsigned CW         = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  input  logic             clr_err,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             afull,
  output logic             aempty,
  output logic             ovf,
  output logic             udf
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic             we;
  logic [CW-1:0]    wr_idx;
  logic [CW-1:0]    rd_idx;

  assign empty  = (count == '0);
  assign full   = (32'(count) == DEPTH);
  assign afull  = (32'(count) >= AFULL_LVL);
  assign aempty = (32'(count) <= AEMPTY_LVL);

  // Push+pop on a non-empty stack overwrites the top; otherwise writes land at count.
  always_comb begin
    we     = 1'b0;
    wr_idx = count;
    rd_idx = count - CW'(2);
    if (push && (!full || pop)) begin
      we = 1'b1;
      if (pop && !empty) begin
        wr_idx = count - CW'(1);
      end
    end
  end

  // Storage carries no reset; writes coincident with rst are harmless.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[AW'(wr_idx)] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      dout  <= '0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else begin
      if (clr_err) begin
        ovf <= 1'b0;
        udf <= 1'b0;
      end
      case ({push, pop})
        2'b10: begin
          if (!full) begin
            count <= count + CW'(1);
            dout  <= din;
          end else begin
            ovf <= 1'b1;
          end
        end
        2'b01: begin
          if (32'(count) >= 2) begin
            count <= count - CW'(1);
            dout  <= mem[AW'(rd_idx)];
          end else if (!empty) begin
            count <= '0;
            dout  <= '0;
          end else begin
            udf <= 1'b1;
          end
        end
        2'b11: begin
          if (empty) begin
            count <= CW'(1);
          end
          dout <= din;
        end
        default: ;
      endcase
    end
  end

endmodule
